// File: rtl/ysyx_22040759_icache_nway_if.sv
// IFU-side and refill-side bus bundle for the N-way instruction cache.
// slave: cache view; master: IFU / AXI bridge view.
interface ysyx_22040759_icache_nway_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [63:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        fence_i;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic [7:0]  mem_req_len;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_rlast;

    modport slave (
        input  ifu_req_valid, ifu_addr, fence_i,
        input  mem_req_ready, mem_rvalid, mem_rdata, mem_rlast,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_len
    );

    modport master (
        output ifu_req_valid, ifu_addr, fence_i,
        output mem_req_ready, mem_rvalid, mem_rdata, mem_rlast,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_len
    );
endinterface

// File: rtl/ysyx_22040759_icache_nway.sv
// N-way set-associative instruction cache with burst refill, per-set
// round-robin replacement and fence.i flush.
// Optional feature macro: YSYX_ICACHE_PERF_EN adds hit/miss counters.
module ysyx_22040759_icache_nway #(
    parameter int unsigned NWAYS      = 2,
    parameter int unsigned NSETS      = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned PADDR_W    = 32
) (
    input  logic clk,
    input  logic rst,
    ysyx_22040759_icache_nway_if.slave bus
`ifdef YSYX_ICACHE_PERF_EN
    ,
    output logic [63:0] perf_hit_cnt,
    output logic [63:0] perf_miss_cnt
`endif
);
    localparam int unsigned OFF_W  = $clog2(LINE_WORDS * 8);
    localparam int unsigned IDX_W  = $clog2(NSETS);
    localparam int unsigned TAG_W  = PADDR_W - IDX_W - OFF_W;
    localparam int unsigned WAY_W  = (NWAYS > 1) ? $clog2(NWAYS) : 1;
    localparam int unsigned BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MREQ, S_REFILL, S_RESP, S_FLUSH
    } state_e;

    state_e state_q, state_d;

    logic [PADDR_W-1:0] addr_q, addr_d;
    logic               fence_pend_q, fence_pend_d;
    logic [WAY_W-1:0]   way_q, way_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic               mem_req_valid_q, mem_req_valid_d;
    logic [63:0]        mem_req_addr_q, mem_req_addr_d;

    logic               valid_q [NWAYS][NSETS];
    logic [TAG_W-1:0]   tag_q   [NWAYS][NSETS];
    logic [WAY_W-1:0]   rr_q    [NSETS];
    logic [63:0]        data_q  [NWAYS][NSETS][LINE_WORDS];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [BEAT_W-1:0]  word_sel;
    logic               accept_c;
    logic               last_beat_c;
    logic               hit_c;
    logic [WAY_W-1:0]   hit_way_c;
    logic               inv_found_c;
    logic [WAY_W-1:0]   inv_way_c;
    logic [WAY_W-1:0]   victim_c;
    logic [WAY_W-1:0]   rr_next_c;
    logic               refill_we_c;
    logic               install_c;
    logic               flush_c;
    logic [63:0]        line_word_c;
    logic               unused_ok;

    assign idx      = addr_q[OFF_W +: IDX_W];
    assign tag      = addr_q[OFF_W + IDX_W +: TAG_W];
    assign word_sel = BEAT_W'((addr_q >> 3) & PADDR_W'(LINE_WORDS - 1));

    // Requests are refused while a flush is due, so fence always wins over a new fetch.
    assign accept_c    = (state_q == S_IDLE) && !fence_pend_q && !bus.fence_i && bus.ifu_req_valid;
    assign last_beat_c = (beat_q == BEAT_W'(LINE_WORDS - 1));
    assign rr_next_c   = (rr_q[idx] == WAY_W'(NWAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
    assign victim_c    = inv_found_c ? inv_way_c : rr_q[idx];

    assign bus.ifu_req_ready  = (state_q == S_IDLE) && !fence_pend_q && !bus.fence_i;
    assign bus.ifu_resp_valid = resp_valid_q;
    assign bus.ifu_resp_data  = resp_data_q;
    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_req_addr   = mem_req_addr_q;
    assign bus.mem_req_len    = 8'(LINE_WORDS - 1);

    assign unused_ok = ^{bus.ifu_addr[63:PADDR_W], bus.mem_rlast, addr_q[1:0]};

    // Tag compare across the set plus lowest-index invalid way search.
    always_comb begin
        hit_c       = 1'b0;
        hit_way_c   = '0;
        inv_found_c = 1'b0;
        inv_way_c   = '0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (!hit_c && valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!inv_found_c && !valid_q[w][idx]) begin
                inv_found_c = 1'b1;
                inv_way_c   = WAY_W'(w);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.fence_i || fence_pend_q) state_d = S_FLUSH;
                else if (bus.ifu_req_valid)      state_d = S_LOOKUP;
            end
            S_LOOKUP: state_d = hit_c ? S_RESP : S_MREQ;
            S_MREQ:   if (bus.mem_req_ready) state_d = S_REFILL;
            S_REFILL: if (bus.mem_rvalid && last_beat_c) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            S_FLUSH:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath controls.
    always_comb begin
        addr_d          = addr_q;
        fence_pend_d    = (state_q == S_FLUSH) ? 1'b0 : (fence_pend_q | bus.fence_i);
        way_d           = way_q;
        beat_d          = beat_q;
        resp_valid_d    = 1'b0;
        resp_data_d     = resp_data_q;
        mem_req_valid_d = (state_d == S_MREQ);
        mem_req_addr_d  = mem_req_addr_q;
        refill_we_c     = 1'b0;
        install_c       = 1'b0;
        flush_c         = (state_q == S_FLUSH);
        line_word_c     = data_q[way_q][idx][word_sel];

        if (accept_c) addr_d = bus.ifu_addr[PADDR_W-1:0];

        case (state_q)
            S_LOOKUP: begin
                way_d = hit_c ? hit_way_c : victim_c;
                if (!hit_c) mem_req_addr_d = 64'({addr_q[PADDR_W-1:OFF_W], OFF_W'(0)});
            end
            S_MREQ: beat_d = '0;
            S_REFILL: begin
                if (bus.mem_rvalid) begin
                    refill_we_c = 1'b1;
                    install_c   = last_beat_c;
                    beat_d      = last_beat_c ? '0 : beat_q + 1'b1;
                end
            end
            S_RESP: begin
                resp_valid_d = 1'b1;
                resp_data_d  = addr_q[2] ? line_word_c[63:32] : line_word_c[31:0];
            end
            default: ;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q          <= '0;
            fence_pend_q    <= 1'b0;
            way_q           <= '0;
            beat_q          <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            addr_q          <= addr_d;
            fence_pend_q    <= fence_pend_d;
            way_q           <= way_d;
            beat_q          <= beat_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
        end
    end

    // Valid bits and replacement pointers; flush and reset clear every line.
    always_ff @(posedge clk) begin
        if (rst || flush_c) begin
            for (int unsigned w = 0; w < NWAYS; w++)
                for (int unsigned s = 0; s < NSETS; s++)
                    valid_q[w][s] <= 1'b0;
            if (rst)
                for (int unsigned s = 0; s < NSETS; s++)
                    rr_q[s] <= '0;
        end else if (install_c) begin
            valid_q[way_q][idx] <= 1'b1;
            rr_q[idx]           <= rr_next_c;
        end
    end

    // Line data and tags; written beat by beat, tag on the final beat.
    always_ff @(posedge clk) begin
        if (refill_we_c) data_q[way_q][idx][beat_q] <= bus.mem_rdata;
        if (install_c)   tag_q[way_q][idx]          <= tag;
    end

`ifdef YSYX_ICACHE_PERF_EN
    logic [63:0] hit_cnt_q, miss_cnt_q;

    // Lookup outcome counters; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (hit_c) hit_cnt_q  <= hit_cnt_q + 64'd1;
            else       miss_cnt_q <= miss_cnt_q + 64'd1;
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22040759_icache_nway.sv
// Self-checking bench for ysyx_22040759_icache_nway (default parameters).
module tb_ysyx_22040759_icache_nway;
    localparam int unsigned NW = 2;
    localparam int unsigned NS = 64;
    localparam int unsigned LW = 4;
    localparam int unsigned LB = LW * 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] salt;

    always #5 clk = ~clk;

    ysyx_22040759_icache_nway_if bus();

`ifdef YSYX_ICACHE_PERF_EN
    logic [63:0] perf_hit_cnt, perf_miss_cnt;
`endif

    ysyx_22040759_icache_nway #(
        .NWAYS(NW), .NSETS(NS), .LINE_WORDS(LW), .PADDR_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef YSYX_ICACHE_PERF_EN
        ,
        .perf_hit_cnt(perf_hit_cnt),
        .perf_miss_cnt(perf_miss_cnt)
`endif
    );

    // Reference cache contents: which line tag sits in which way of which set.
    bit          m_valid [NW][NS];
    int unsigned m_tag   [NW][NS];
    int unsigned m_rr    [NS];

    function automatic logic [63:0] memw(input logic [31:0] a);
        return {a ^ salt, (~a) + salt};
    endfunction

    function automatic logic [31:0] exp_insn(input logic [31:0] a);
        logic [63:0] w;
        w = memw(a & ~32'h7);
        return a[2] ? w[63:32] : w[31:0];
    endfunction

    function automatic void model_reset();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++) m_valid[w][s] = 1'b0;
        for (int s = 0; s < NS; s++) m_rr[s] = 0;
    endfunction

    function automatic void model_flush();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++) m_valid[w][s] = 1'b0;
    endfunction

    // Returns 1 on hit; on a miss installs the line in the victim way.
    function automatic bit model_access(input logic [31:0] a);
        int unsigned s, t;
        int v;
        s = (a / LB) % NS;
        t = a / (LB * NS);
        for (int w = 0; w < NW; w++)
            if (m_valid[w][s] && m_tag[w][s] == t) return 1'b1;
        v = -1;
        for (int w = 0; w < NW; w++)
            if (v < 0 && !m_valid[w][s]) v = w;
        if (v < 0) v = int'(m_rr[s]);
        m_valid[v][s] = 1'b1;
        m_tag[v][s]   = t;
        m_rr[s]       = (m_rr[s] + 1) % NW;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = '0;
        bus.fence_i       = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
        bus.mem_rlast     = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_fence();
        bus.fence_i = 1'b1;
        @(posedge clk); #1;
        bus.fence_i = 1'b0;
    endtask

    // Drives one fetch, plays the memory side, and reports what was observed.
    task automatic do_fetch(input logic [63:0] a, input bit fence_mid,
                            output logic [31:0] data, output int nreq, output int lat,
                            output logic [63:0] raddr, output logic [7:0] rlen,
                            output bit addr_stable, output logic resp_after,
                            output logic [31:0] data_after);
        int n, beat, waitc;
        bit refill, hs, done, seen;
        logic [31:0] line;
        nreq = 0; lat = -1; data = '0; raddr = '0; rlen = '0;
        addr_stable = 1'b1; resp_after = 1'b0; data_after = '0;
        line = a[31:0] & ~32'(LB - 1);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = a;
        waitc = 0;
        while (!bus.ifu_req_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = {$urandom, $urandom};
        n = 0; beat = 0; refill = 1'b0; hs = 1'b0; done = 1'b0; seen = 1'b0;
        while (!done && n <= 300) begin
            if (hs) begin nreq++; refill = 1'b1; beat = 0; hs = 1'b0; end
            bus.mem_req_ready = 1'b0;
            bus.mem_rvalid    = 1'b0;
            bus.mem_rlast     = 1'b0;
            bus.fence_i       = 1'b0;
            bus.mem_rdata     = {$urandom, $urandom};
            if (bus.ifu_resp_valid) begin
                done = 1'b1;
                lat  = n;
                data = bus.ifu_resp_data;
            end else begin
                if (bus.mem_req_valid) begin
                    if (!seen) begin raddr = bus.mem_req_addr; seen = 1'b1; end
                    else if (bus.mem_req_addr !== raddr) addr_stable = 1'b0;
                    rlen = bus.mem_req_len;
                    if ($urandom_range(0, 2) != 0) begin
                        bus.mem_req_ready = 1'b1;
                        hs = 1'b1;
                    end
                end
                if (refill && beat < int'(LW) && $urandom_range(0, 3) != 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = memw(line + 32'(beat * 8));
                    bus.mem_rlast  = (beat == int'(LW) - 1);
                    if (fence_mid && beat == 1) bus.fence_i = 1'b1;
                    beat++;
                end
                @(posedge clk); #1;
                n++;
            end
        end
        idle_inputs();
        @(posedge clk); #1;
        resp_after = bus.ifu_resp_valid;
        data_after = bus.ifu_resp_data;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.ifu_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.ifu_req_ready); end
        checks++; if (bus.ifu_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b want=0", bus.ifu_resp_valid); end
        checks++; if (bus.ifu_resp_data !== 32'h0) begin failures++; $display("FAIL reset_resp_data got=%h want=0", bus.ifu_resp_data); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid got=%b want=0", bus.mem_req_valid); end
        checks++; if (bus.mem_req_addr !== 64'h0) begin failures++; $display("FAIL reset_mem_req_addr got=%h want=0", bus.mem_req_addr); end
    endtask

    task automatic test_cold_fetch();
        logic [31:0] d, d2; int nreq, lat; logic [63:0] ra; logic [7:0] rl; bit st; logic ra2;
        logic [63:0] b0, b3;
        b0 = memw(32'h8000_0000);
        b3 = memw(32'h8000_0018);
        do_fetch(64'h8000_0000, 1'b0, d, nreq, lat, ra, rl, st, ra2, d2);
        void'(model_access(32'h8000_0000));
        checks++; if (nreq !== 1) begin failures++; $display("FAIL cold_nreq got=%0d want=1", nreq); end
        checks++; if (ra !== 64'h8000_0000) begin failures++; $display("FAIL cold_req_addr got=%h want=80000000", ra); end
        checks++; if (rl !== 8'd3) begin failures++; $display("FAIL cold_req_len got=%0d want=3", rl); end
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL cold_addr_stable got=%b want=1", st); end
        checks++; if (d !== b0[31:0]) begin failures++; $display("FAIL cold_data got=%h want=%h", d, b0[31:0]); end
        checks++; if (ra2 !== 1'b0 || d2 !== d) begin failures++; $display("FAIL cold_resp_pulse valid_after=%b data_after=%h want 0/%h", ra2, d2, d); end

        do_fetch(64'h8000_0004, 1'b0, d, nreq, lat, ra, rl, st, ra2, d2);
        void'(model_access(32'h8000_0004));
        checks++; if (nreq !== 0) begin failures++; $display("FAIL hit4_nreq got=%0d want=0", nreq); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL hit4_latency got=%0d want=2", lat); end
        checks++; if (d !== b0[63:32]) begin failures++; $display("FAIL hit4_data got=%h want=%h", d, b0[63:32]); end
        checks++; if (ra2 !== 1'b0) begin failures++; $display("FAIL hit4_resp_pulse got=%b want=0", ra2); end

        do_fetch(64'h8000_0018, 1'b0, d, nreq, lat, ra, rl, st, ra2, d2);
        void'(model_access(32'h8000_0018));
        checks++; if (nreq !== 0) begin failures++; $display("FAIL hit18_nreq got=%0d want=0", nreq); end
        checks++; if (d !== b3[31:0]) begin failures++; $display("FAIL hit18_data got=%h want=%h", d, b3[31:0]); end
    endtask

    task automatic test_eviction();
        logic [31:0] d, d2; int nreq, lat; logic [63:0] ra; logic [7:0] rl; bit st; logic ra2;
        logic [31:0] seq [5];
        int want [5];
        seq[0] = 32'h8000_0800; want[0] = 1;
        seq[1] = 32'h8000_1000; want[1] = 1;
        seq[2] = 32'h8000_0000; want[2] = 1;
        seq[3] = 32'h8000_1004; want[3] = 0;
        seq[4] = 32'h8000_0800; want[4] = 1;
        for (int i = 0; i < 5; i++) begin
            do_fetch({32'h0, seq[i]}, 1'b0, d, nreq, lat, ra, rl, st, ra2, d2);
            void'(model_access(seq[i]));
            checks++; if (nreq !== want[i]) begin failures++; $display("FAIL evict_nreq[%0d] addr=%h got=%0d want=%0d", i, seq[i], nreq, want[i]); end
            checks++; if (d !== exp_insn(seq[i])) begin failures++; $display("FAIL evict_data[%0d] got=%h want=%h", i, d, exp_insn(seq[i])); end
        end
    endtask

    task automatic test_fence_refill();
        logic [31:0] d, d2; int nreq, lat; logic [63:0] ra; logic [7:0] rl; bit st; logic ra2;
        do_fetch(64'h8000_0044, 1'b1, d, nreq, lat, ra, rl, st, ra2, d2);
        void'(model_access(32'h8000_0044));
        model_flush();
        checks++; if (nreq !== 1 || d !== exp_insn(32'h8000_0044)) begin failures++; $display("FAIL fence_refill_resp nreq=%0d data=%h want 1/%h", nreq, d, exp_insn(32'h8000_0044)); end
        do_fetch(64'h8000_0044, 1'b0, d, nreq, lat, ra, rl, st, ra2, d2);
        void'(model_access(32'h8000_0044));
        checks++; if (nreq !== 1) begin failures++; $display("FAIL fence_refill_refetch_nreq got=%0d want=1", nreq); end
        checks++; if (d !== exp_insn(32'h8000_0044)) begin failures++; $display("FAIL fence_refill_refetch_data got=%h want=%h", d, exp_insn(32'h8000_0044)); end
    endtask

    task automatic test_fence_with_req();
        logic [31:0] d, d2; int nreq, lat; logic [63:0] ra; logic [7:0] rl; bit st; logic ra2;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0044;
        bus.fence_i       = 1'b1;
        #1;
        checks++; if (bus.ifu_req_ready !== 1'b0) begin failures++; $display("FAIL fence_req_ready_same got=%b want=0", bus.ifu_req_ready); end
        @(posedge clk); #1;
        bus.fence_i = 1'b0;
        checks++; if (bus.ifu_req_ready !== 1'b0) begin failures++; $display("FAIL fence_req_ready_flush got=%b want=0", bus.ifu_req_ready); end
        model_flush();
        do_fetch(64'h8000_0044, 1'b0, d, nreq, lat, ra, rl, st, ra2, d2);
        void'(model_access(32'h8000_0044));
        checks++; if (nreq !== 1 || d !== exp_insn(32'h8000_0044)) begin failures++; $display("FAIL fence_req_after nreq=%0d data=%h want 1/%h", nreq, d, exp_insn(32'h8000_0044)); end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] d, d2; int nreq, lat; logic [63:0] ra; logic [7:0] rl; bit st; logic ra2;
        int waitc; bit bad_resp, bad_req;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_2000;
        waitc = 0;
        while (!bus.ifu_req_ready && waitc < 50) begin @(posedge clk); #1; waitc++; end
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        waitc = 0;
        while (!bus.mem_req_valid && waitc < 20) begin @(posedge clk); #1; waitc++; end
        checks++;
        if (!bus.mem_req_valid) begin
            failures++; $display("FAIL rst_refill_req_timeout got=0 want=1");
            apply_reset();
            return;
        end
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        bad_resp = 1'b0; bad_req = 1'b0;
        for (int b = 0; b < int'(LW); b++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = memw(32'h8000_2000 + 32'(b * 8));
            bus.mem_rlast  = (b == int'(LW) - 1);
            rst = (b == 1);
            @(posedge clk); #1;
            rst = 1'b0;
            if (b == 1) begin
                checks++; if (bus.ifu_req_ready !== 1'b1) begin failures++; $display("FAIL rst_refill_ready got=%b want=1", bus.ifu_req_ready); end
            end
            if (bus.ifu_resp_valid !== 1'b0) bad_resp = 1'b1;
        end
        idle_inputs();
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.ifu_resp_valid !== 1'b0) bad_resp = 1'b1;
            if (bus.mem_req_valid !== 1'b0) bad_req = 1'b1;
        end
        model_reset();
        checks++; if (bad_resp) begin failures++; $display("FAIL rst_refill_no_resp got=1 want=0"); end
        checks++; if (bad_req) begin failures++; $display("FAIL rst_refill_no_mem_req got=1 want=0"); end
        do_fetch(64'h8000_0000, 1'b0, d, nreq, lat, ra, rl, st, ra2, d2);
        void'(model_access(32'h8000_0000));
        checks++; if (nreq !== 1) begin failures++; $display("FAIL rst_refill_refetch_nreq got=%0d want=1", nreq); end
        checks++; if (d !== exp_insn(32'h8000_0000)) begin failures++; $display("FAIL rst_refill_refetch_data got=%h want=%h", d, exp_insn(32'h8000_0000)); end
    endtask

    task automatic test_random();
        logic [31:0] d, d2; int nreq, lat; logic [63:0] ra; logic [7:0] rl; bit st; logic ra2;
        logic [31:0] a32, line; logic [63:0] a; bit hit;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                pulse_fence();
                model_flush();
            end
            a32 = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 5)
                | (32'($urandom_range(0, 3)) << 3) | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
            a    = {$urandom, a32};
            line = a32 & ~32'(LB - 1);
            hit  = model_access(a32);
            do_fetch(a, 1'b0, d, nreq, lat, ra, rl, st, ra2, d2);
            checks++; if (nreq !== (hit ? 0 : 1)) begin failures++; $display("FAIL rand_nreq[%0d] addr=%h got=%0d want=%0d", i, a32, nreq, hit ? 0 : 1); end
            checks++; if (d !== exp_insn(a32)) begin failures++; $display("FAIL rand_data[%0d] addr=%h got=%h want=%h", i, a32, d, exp_insn(a32)); end
            if (hit) begin
                checks++; if (lat !== 2) begin failures++; $display("FAIL rand_hit_latency[%0d] got=%0d want=2", i, lat); end
            end else begin
                checks++; if (ra !== {32'h0, line} || !st) begin failures++; $display("FAIL rand_req_addr[%0d] got=%h stable=%b want=%h", i, ra, st, line); end
            end
        end
    endtask

`ifdef YSYX_ICACHE_PERF_EN
    task automatic test_perf();
        logic [31:0] d, d2; int nreq, lat; logic [63:0] ra; logic [7:0] rl; bit st; logic ra2;
        logic [31:0] seq [5];
        apply_reset();
        seq[0] = 32'h8000_0100; seq[1] = 32'h8000_0104; seq[2] = 32'h8000_0108;
        seq[3] = 32'h8000_0200; seq[4] = 32'h8000_020c;
        for (int i = 0; i < 5; i++) begin
            do_fetch({32'h0, seq[i]}, 1'b0, d, nreq, lat, ra, rl, st, ra2, d2);
            void'(model_access(seq[i]));
        end
        checks++; if (perf_hit_cnt !== 64'd3) begin failures++; $display("FAIL perf_hit got=%0d want=3", perf_hit_cnt); end
        checks++; if (perf_miss_cnt !== 64'd2) begin failures++; $display("FAIL perf_miss got=%0d want=2", perf_miss_cnt); end
        pulse_fence();
        @(posedge clk); #1;
        model_flush();
        checks++; if (perf_hit_cnt !== 64'd3 || perf_miss_cnt !== 64'd2) begin failures++; $display("FAIL perf_after_fence got=%0d/%0d want=3/2", perf_hit_cnt, perf_miss_cnt); end
    endtask
`endif

    initial begin
        salt = $urandom;
        rst  = 1'b1;
        idle_inputs();
        test_reset();
        test_cold_fetch();
        test_eviction();
        test_fence_refill();
        test_fence_with_req();
        test_reset_mid_refill();
        test_random();
`ifdef YSYX_ICACHE_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
